// File: rtl/boot_loader_pkg.sv
// boot_loader shared definitions: host commands,
// FSM state encoding and instruction width.
package boot_pkg;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_RUN
  } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader host byte stream: valid/ready handshake.
// master = host side, slave = loader side.
interface boot_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/boot_loader_cycle_counter.sv
// boot_cycle_counter: 32-bit saturating RUN cycle counter.
// Timeout compare only with BOOT_LOADER_TIMEOUT_EN.
module boot_cycle_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] count_o,
  output logic        timeout_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // clear has priority; hold at all-ones once saturated
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  assign count_o = count_q;

`ifdef BOOT_LOADER_TIMEOUT_EN
  // fires on the RUN cycle whose count reaches the limit
  assign timeout_o = en_i &&
    (({1'b0, count_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES});
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: rtl/boot_loader.sv
// boot_loader: host byte-stream loader and run sequencer.
// Optional watchdog: define BOOT_LOADER_TIMEOUT_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH     = 1024,
  parameter int unsigned DMEM_DEPTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic               CLK,
  input  logic               RESET,
  boot_loader_if.slave       host,
  output logic               core_reset,
  input  logic               halt_in,
  output logic               imem_we,
  output logic [15:0]        imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               dmem_we,
  output logic [7:0]         dmem_addr,
  output logic [7:0]         dmem_wdata,
  output logic               done,
  output logic               err,
  output logic [31:0]        cycle_count
);

  boot_state_t state_q, state_d;

  logic               cmd_imem_q, cmd_imem_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         lo_q, lo_d;
  logic               phase_q, phase_d;
  logic               imem_we_q, imem_we_d;
  logic [15:0]        imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
  logic               dmem_we_q, dmem_we_d;
  logic [7:0]         dmem_addr_q, dmem_addr_d;
  logic [7:0]         dmem_wdata_q, dmem_wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic acc;
  logic word_fin;
  logic run_enter;
  logic in_run;
  logic tmo;

  assign acc       = host.in_valid & host.in_ready;
  assign in_run    = (state_q == ST_RUN);
  assign word_fin  = acc && (state_q == ST_PAYLOAD) &&
                     (!cmd_imem_q || phase_q);
  assign run_enter = acc && (state_q == ST_IDLE) &&
                     (host.in_data == CMD_RUN);

  boot_cycle_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cnt (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .clr_i     (run_enter),
    .en_i      (in_run),
    .count_o   (cycle_count),
    .timeout_o (tmo)
  );

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          unique case (1'b1)
            (host.in_data == CMD_IMEM),
            (host.in_data == CMD_DMEM): state_d = ST_LEN_HI;
            (host.in_data == CMD_RUN):  state_d = ST_RUN;
            default:                    state_d = ST_IDLE;
          endcase
        end
      end
      ST_LEN_HI: begin
        if (acc) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (acc) begin
          state_d = ({len_q[15:8], host.in_data} == 16'd0) ?
                    ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (word_fin && (len_q == 16'd1)) state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (halt_in || tmo) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state-decoded outputs; ready is held low while in reset
  always_comb begin
    core_reset    = (state_q != ST_RUN);
    host.in_ready = !RESET && (state_q != ST_RUN);
  end

  // datapath and flag registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cmd_imem_q   <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      lo_q         <= '0;
      phase_q      <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cmd_imem_q   <= cmd_imem_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      phase_q      <= phase_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // byte parsing, word assembly and write strobes
  always_comb begin
    cmd_imem_d   = cmd_imem_q;
    len_d        = len_q;
    addr_d       = addr_q;
    lo_d         = lo_q;
    phase_d      = phase_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          unique case (1'b1)
            (host.in_data == CMD_IMEM): cmd_imem_d = 1'b1;
            (host.in_data == CMD_DMEM): cmd_imem_d = 1'b0;
            (host.in_data == CMD_RUN):  done_d     = 1'b0;
            default:                    err_d      = 1'b1;
          endcase
        end
      end
      ST_LEN_HI: begin
        if (acc) len_d[15:8] = host.in_data;
      end
      ST_LEN_LO: begin
        if (acc) begin
          len_d   = {len_q[15:8], host.in_data};
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (acc && cmd_imem_q && !phase_q) begin
          lo_d    = host.in_data;
          phase_d = 1'b1;
        end else if (acc) begin
          phase_d = 1'b0;
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 16'd1;
          if (cmd_imem_q) begin
            if ({16'd0, addr_q} < IMEM_DEPTH) begin
              imem_we_d    = 1'b1;
              imem_addr_d  = addr_q;
              imem_wdata_d = {host.in_data[0], lo_q};
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if ({16'd0, addr_q} < DMEM_DEPTH) begin
              dmem_we_d    = 1'b1;
              dmem_addr_d  = addr_q[7:0];
              dmem_wdata_d = host.in_data;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          done_d = 1'b1;
        end else if (tmo) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: random frames vs a frame-parsing model,
// plus directed load, run, error and reset checks.
module tb_boot_loader;
  import boot_pkg::*;

  localparam int IDEP = 1024;
  localparam int DDEP = 256;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        halt_in = 1'b0;
  logic        core_reset;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [8:0]  imem_wdata;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        done;
  logic        err;
  logic [31:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  bq[$];
  logic [25:0] obs_q[$];
  logic [25:0] exp_q[$];
  int          dm_cyc[$];
  logic        exp_err = 1'b0;

  boot_loader_if bus();

  boot_loader #(
    .IMEM_DEPTH     (IDEP),
    .DMEM_DEPTH     (DDEP),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .host        (bus),
    .core_reset  (core_reset),
    .halt_in     (halt_in),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .done        (done),
    .err         (err),
    .cycle_count (cycle_count)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc++;
    if (!RESET) begin
      if (imem_we)
        obs_q.push_back({1'b0, imem_addr, imem_wdata});
      if (dmem_we) begin
        obs_q.push_back({1'b1, 8'h00, dmem_addr, 1'b0, dmem_wdata});
        dm_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
    end
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 100) check("rdy_wait", {31'd0, bus.in_ready}, 1);
    @(posedge CLK);
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic play(input bit gaps);
    foreach (bq[i]) send(bq[i], gaps);
    idle(4);
  endtask

  // walks the byte list frame by frame from idle
  task automatic model();
    int i, n, h;
    i = 0;
    while (i < bq.size()) begin
      h = int'(bq[i]);
      i++;
      if (h == 1 || h == 2) begin
        n = int'({bq[i], bq[i+1]});
        i += 2;
        for (int w = 0; w < n; w++) begin
          if (h == 1) begin
            if (w < IDEP)
              exp_q.push_back({1'b0, 16'(w), bq[i+1][0], bq[i]});
            else
              exp_err = 1'b1;
            i += 2;
          end else begin
            if (w < DDEP)
              exp_q.push_back({1'b1, 16'(w), 1'b0, bq[i]});
            else
              exp_err = 1'b1;
            i++;
          end
        end
      end else if (h != 3) begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_n"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, {6'd0, obs_q[i]}, {6'd0, exp_q[i]});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rdy"}, {31'd0, bus.in_ready}, 0);
    check({tag, "_crst"}, {31'd0, core_reset}, 1);
    check({tag, "_iwe"}, {31'd0, imem_we}, 0);
    check({tag, "_dwe"}, {31'd0, dmem_we}, 0);
    check({tag, "_iad"}, {16'd0, imem_addr}, 0);
    check({tag, "_dad"}, {24'd0, dmem_addr}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
    check({tag, "_cc"}, cycle_count, 0);
  endtask

  // sends CMD_RUN, counts core_reset-low cycles until it rises
  task automatic do_run(input int halt_at, output int low);
    bit exited;
    send(CMD_RUN, 1'b0);
    low = 0;
    exited = 1'b0;
    for (int k = 0; k < 300 && !exited; k++) begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
      if (core_reset) begin
        exited = 1'b1;
      end else begin
        low++;
        if (low == halt_at) halt_in = 1'b1;
      end
    end
    if (!exited) check("run_exit", {31'd0, core_reset}, 1);
    halt_in = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2 RESET = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(negedge CLK);
    RESET = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    int low;
    int kind, n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge CLK);
    chk_reset_vals("por");
    RESET = 1'b0;
    @(negedge CLK);
    check("rdy_idle", {31'd0, bus.in_ready}, 1);

    // IMEM frame, second high byte has junk upper bits
    bq = '{8'h01, 8'h00, 8'h02, 8'hA5, 8'h01, 8'h3C, 8'hFE};
    model();
    play(1'b0);
    check("imem_cnt", obs_q.size(), 2);
    check("imem_w0", {6'd0, obs_q[0]}, {6'd0, 1'b0, 16'd0, 9'h1A5});
    check("imem_w1", {6'd0, obs_q[1]}, {6'd0, 1'b0, 16'd1, 9'h03C});
    cmp_writes("imem");

    // DMEM back-to-back, strobes on consecutive cycles
    dm_cyc.delete();
    bq = '{8'h02, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    model();
    play(1'b0);
    check("dm_cnt", dm_cyc.size(), 3);
    check("dm_b2b0", dm_cyc[1] - dm_cyc[0], 1);
    check("dm_b2b1", dm_cyc[2] - dm_cyc[1], 1);
    cmp_writes("dmem");

    // run, halt raised 10 cycles after core_reset falls
    do_run(11, low);
    check("run_low", low, 11);
    check("run_cc", cycle_count, 11);
    check("run_done", {31'd0, done}, 1);
    check("run_rdy", {31'd0, bus.in_ready}, 1);

    // halt already high on the first RUN cycle
    halt_in = 1'b1;
    do_run(0, low);
    check("h1_low", low, 1);
    check("h1_cc", cycle_count, 1);
    check("h1_done", {31'd0, done}, 1);

    // unknown header, then zero-length DMEM, then a real frame
    bq = '{8'h7F, 8'h02, 8'h00, 8'h00};
    model();
    play(1'b0);
    cmp_writes("badhdr");
    check("badhdr_crst", {31'd0, core_reset}, 1);
    bq = '{8'h02, 8'h00, 8'h01, 8'h5A};
    model();
    play(1'b0);
    cmp_writes("after0");

    // reset in the middle of a payload
    bq = '{8'h02, 8'h00, 8'h05, 8'hAA, 8'hBB};
    foreach (bq[i]) send(bq[i], 1'b0);
    pulse_reset();
    bq = '{8'h02, 8'h00, 8'h01, 8'h77};
    model();
    play(1'b0);
    cmp_writes("postrst");

    // DMEM overrun past depth: tail suppressed, err set
    bq = '{8'h02, 8'h01, 8'h02};
    for (int i = 0; i < 258; i++) bq.push_back(8'($urandom));
    model();
    play(1'b0);
    cmp_writes("dovr");
    pulse_reset();

    // random frame mixes with random gaps
    for (int t = 0; t < 8; t++) begin
      bq.delete();
      for (int f = 0; f < 3; f++) begin
        kind = $urandom_range(0, 9);
        n = $urandom_range(0, 12);
        if (kind == 0) begin
          bq.push_back(8'($urandom_range(4, 255)));
        end else begin
          bq.push_back(kind < 5 ? CMD_IMEM : CMD_DMEM);
          bq.push_back(8'h00);
          bq.push_back(8'(n));
          for (int w = 0; w < (kind < 5 ? 2 * n : n); w++)
            bq.push_back(8'($urandom));
        end
      end
      model();
      play(1'b1);
      cmp_writes("rnd");
    end

`ifdef BOOT_LOADER_TIMEOUT_EN
    pulse_reset();
    halt_in = 1'b1;
    do_run(0, low);
    check("pre_done", {31'd0, done}, 1);
    do_run(0, low);
    check("to_low", low, 50);
    check("to_cc", cycle_count, 50);
    check("to_err", {31'd0, err}, 1);
    check("to_done", {31'd0, done}, 0);
    check("to_crst", {31'd0, core_reset}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
